// File: rtl/i_fetch_decode.sv
// i_fetch_decode: instruction front-end for the I-type execution unit.
// Fetches one 32-bit word at a time over a req/ack memory port, decodes it
// as an OP-IMM instruction and holds the result on a valid/ready issue port.
// All outputs come straight from flops.

module i_fetch_decode #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        issue_valid,
   input  logic        issue_ready,
   output logic [31:0] idata,
   output logic [31:0] imm,
   output logic [4:0]  rs1,
   output logic [4:0]  rd,
   output logic [31:0] pc,
   output logic        illegal,
   output logic [31:0] issue_count
);

   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [2:0] F3_SLLI     = 3'b001;
   localparam logic [2:0] F3_SRXI     = 3'b101;
   localparam logic [6:0] F7_ZERO     = 7'b0000000;
   localparam logic [6:0] F7_ARITH    = 7'b0100000;
   localparam logic [31:0] WORD_ALIGN = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DRAIN = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;   // PC of the next word to fetch
   logic [31:0] addr_q, addr_d;           // address currently on the bus
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic [31:0] idata_q, idata_d;
   logic [31:0] imm_q, imm_d;
   logic [4:0]  rs1_q, rs1_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] issue_pc_q, issue_pc_d;
   logic        illegal_q, illegal_d;
   logic [31:0] count_q, count_d;

   logic [6:0]  dec_opcode;
   logic [2:0]  dec_funct3;
   logic [6:0]  dec_funct7;
   logic [31:0] dec_imm;
   logic        dec_illegal;
   logic [31:0] redirect_target;
   logic        transfer;

   assign redirect_target = redirect_pc & WORD_ALIGN;
   assign transfer        = valid_q & issue_ready;

   // Decode the word arriving from memory; only used on the capture cycle.
   always_comb begin
      dec_opcode  = imem_rdata[6:0];
      dec_funct3  = imem_rdata[14:12];
      dec_funct7  = imem_rdata[31:25];
      dec_illegal = 1'b0;
      if ((dec_funct3 == F3_SLLI) || (dec_funct3 == F3_SRXI)) begin
         dec_imm = {27'b0, imem_rdata[24:20]};
      end else begin
         dec_imm = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
      end
      if (dec_opcode != OP_IMM) begin
         dec_illegal = 1'b1;
      end
      if ((dec_funct3 == F3_SLLI) && (dec_funct7 != F7_ZERO)) begin
         dec_illegal = 1'b1;
      end
      if ((dec_funct3 == F3_SRXI) && (dec_funct7 != F7_ZERO) && (dec_funct7 != F7_ARITH)) begin
         dec_illegal = 1'b1;
      end
   end

   // Next-state, PC tracking, capture and issue bookkeeping.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      idata_d    = idata_q;
      imm_d      = imm_q;
      rs1_d      = rs1_q;
      rd_d       = rd_q;
      issue_pc_d = issue_pc_q;
      illegal_d  = illegal_q;
      count_d    = count_q;

      case (state_q)
         FETCH: begin
            if (req_q) begin
               if (redirect) begin
                  // A coincident ack is simply dropped; without one the
                  // old request is still owed a response, so drain it.
                  fetch_pc_d = redirect_target;
                  state_d    = imem_ack ? FETCH : DRAIN;
               end else if (imem_ack) begin
                  idata_d    = imem_rdata;
                  imm_d      = dec_imm;
                  rs1_d      = imem_rdata[19:15];
                  rd_d       = imem_rdata[11:7];
                  issue_pc_d = addr_q;
                  illegal_d  = dec_illegal;
                  state_d    = ISSUE;
               end
            end else if (redirect) begin
               // First cycle out of reset: nothing outstanding yet.
               fetch_pc_d = redirect_target;
            end
         end

         DRAIN: begin
            if (redirect) begin
               fetch_pc_d = redirect_target;
            end
            if (imem_ack) begin
               state_d = FETCH;
            end
         end

         ISSUE: begin
            if (transfer) begin
               count_d = count_q + 32'd1;
            end
            if (redirect) begin
               fetch_pc_d = redirect_target;
               state_d    = FETCH;
            end else if (transfer) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = FETCH;
            end
         end

         default: begin
            state_d = FETCH;
         end
      endcase

      // Bus address only follows the PC while fetching; in DRAIN it must
      // keep showing the address of the request still in flight.
      req_d   = (state_d != ISSUE);
      valid_d = (state_d == ISSUE);
      addr_d  = (state_d == FETCH) ? fetch_pc_d : addr_q;
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         idata_q    <= 32'd0;
         imm_q      <= 32'd0;
         rs1_q      <= 5'd0;
         rd_q       <= 5'd0;
         issue_pc_q <= 32'd0;
         illegal_q  <= 1'b0;
         count_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         valid_q    <= valid_d;
         idata_q    <= idata_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rd_q       <= rd_d;
         issue_pc_q <= issue_pc_d;
         illegal_q  <= illegal_d;
         count_q    <= count_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign issue_valid = valid_q;
   assign idata       = idata_q;
   assign imm         = imm_q;
   assign rs1         = rs1_q;
   assign rd          = rd_q;
   assign pc          = issue_pc_q;
   assign illegal     = illegal_q;
   assign issue_count = count_q;

endmodule

// File: tb/tb_i_fetch_decode.sv
// Bench for i_fetch_decode: transaction-level model (expected-issue queue
// plus fetch PC) checked every cycle, with literal pins from the stimulus.

module tb_i_fetch_decode;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        issue_valid;
   logic        issue_ready;
   logic [31:0] idata;
   logic [31:0] imm;
   logic [4:0]  rs1;
   logic [4:0]  rd;
   logic [31:0] pc;
   logic        illegal;
   logic [31:0] issue_count;

   always #5 clk = ~clk;

   i_fetch_decode #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .idata(idata), .imm(imm), .rs1(rs1), .rd(rd), .pc(pc),
      .illegal(illegal), .issue_count(issue_count)
   );

   // ---------------- shared bench state ----------------
   logic [31:0] mem_word;
   int          mem_wait;
   int          pin_sel [8];
   logic [31:0] pin_val [8];
   int          pin_n;
   int          preset_seq;
   int          n_cmp;
   int          n_fail;

   assign imem_rdata = mem_word;

   typedef struct packed {
      logic [31:0] idata;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   exp_t q[$];

   // Decode straight from the OP-IMM field rules.
   function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] a);
      exp_t       e;
      logic [2:0] f3;
      logic [6:0] f7;
      f3      = w[14:12];
      f7      = w[31:25];
      e.idata = w;
      e.pc    = a;
      e.rs1   = w[19:15];
      e.rd    = w[11:7];
      if (f3 == 3'd1 || f3 == 3'd5) e.imm = {27'd0, w[24:20]};
      else                          e.imm = {{20{w[31]}}, w[31:20]};
      e.ill = (w[6:0] != 7'h13) || (f3 == 3'd1 && f7 != 7'h00) ||
              (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      return e;
   endfunction

   function automatic string pin_name(input int s);
      case (s)
         0: return "pin_imem_addr";
         1: return "pin_imm";
         2: return "pin_rd";
         3: return "pin_rs1";
         4: return "pin_illegal";
         5: return "pin_issue_count";
         6: return "pin_issue_valid";
         7: return "pin_idata";
         8: return "pin_pc";
         9: return "pin_imem_req";
         default: return "wait_timeout";
      endcase
   endfunction

   function automatic logic [31:0] pin_act(input int s);
      case (s)
         0: return imem_addr;
         1: return imm;
         2: return {27'd0, rd};
         3: return {27'd0, rs1};
         4: return {31'd0, illegal};
         5: return issue_count;
         6: return {31'd0, issue_valid};
         7: return idata;
         8: return pc;
         9: return {31'd0, imem_req};
         default: return 32'd1;   // a timeout pin always reports
      endcase
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   initial begin : mem
      int cnt;
      cnt      = 0;
      imem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rst || !imem_req) begin
            imem_ack = 1'b0;
            cnt      = 0;
         end else if (cnt >= mem_wait) begin
            imem_ack = 1'b1;
            cnt      = 0;
         end else begin
            imem_ack = 1'b0;
            cnt++;
         end
      end
   end

   // ---------------- model + compare process ----------------
   initial begin : mon
      logic        m_armed;
      logic        m_stale;
      logic [31:0] m_stale_addr;
      logic [31:0] m_pc;
      logic [31:0] m_count;
      int          seen_seq;
      logic        req_e;
      logic [31:0] rp;
      exp_t        e;
      n_cmp        = 0;
      n_fail       = 0;
      m_armed      = 1'b0;
      m_stale      = 1'b0;
      m_stale_addr = 32'd0;
      m_pc         = RPC;
      m_count      = 32'd0;
      seen_seq     = 0;
      forever begin
         @(negedge clk);
         if (preset_seq != seen_seq) begin
            seen_seq = preset_seq;
            m_count  = 32'hFFFF_FFFF;
         end
         if (rst) begin
            q.delete();
            m_armed = 1'b0;
            m_stale = 1'b0;
            m_pc    = RPC;
            m_count = 32'd0;
            cmp("rst_imem_req", {31'd0, imem_req}, 32'd0);
            cmp("rst_imem_addr", imem_addr, RPC);
            cmp("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
            cmp("rst_idata", idata, 32'd0);
            cmp("rst_imm", imm, 32'd0);
            cmp("rst_rs1_rd", {22'd0, rs1, rd}, 32'd0);
            cmp("rst_pc", pc, 32'd0);
            cmp("rst_illegal", {31'd0, illegal}, 32'd0);
            cmp("rst_issue_count", issue_count, 32'd0);
         end else begin
            req_e = m_armed && (q.size() == 0);
            cmp("imem_req", {31'd0, imem_req}, {31'd0, req_e});
            if (req_e) cmp("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
            cmp("issue_valid", {31'd0, issue_valid}, {31'd0, (q.size() != 0)});
            if (q.size() != 0) begin
               e = q[0];
               cmp("idata", idata, e.idata);
               cmp("imm", imm, e.imm);
               cmp("pc", pc, e.pc);
               cmp("rs1", {27'd0, rs1}, {27'd0, e.rs1});
               cmp("rd", {27'd0, rd}, {27'd0, e.rd});
               cmp("illegal", {31'd0, illegal}, {31'd0, e.ill});
            end
            cmp("issue_count", issue_count, m_count);
            for (int i = 0; i < pin_n; i++) begin
               cmp(pin_name(pin_sel[i]), pin_act(pin_sel[i]), pin_val[i]);
            end

            // advance the model by the events of the coming edge
            rp = {redirect_pc[31:2], 2'b00};
            if (!m_armed) begin
               m_armed = 1'b1;
               if (redirect) m_pc = rp;
            end else if (q.size() != 0) begin
               if (issue_ready) begin
                  m_count = m_count + 32'd1;
                  void'(q.pop_front());
                  m_pc = redirect ? rp : m_pc + 32'd4;
               end else if (redirect) begin
                  void'(q.pop_front());
                  m_pc = rp;
               end
            end else if (m_stale) begin
               if (imem_ack) m_stale = 1'b0;
               if (redirect) m_pc = rp;
            end else if (redirect) begin
               if (!imem_ack) begin
                  m_stale      = 1'b1;
                  m_stale_addr = m_pc;
               end
               m_pc = rp;
            end else if (imem_ack) begin
               q.push_back(model_decode(imem_rdata, m_pc));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick;
      @(posedge clk);
      #1;
      pin_n = 0;
   endtask

   task automatic pin(input int sel, input logic [31:0] v);
      pin_sel[pin_n] = sel;
      pin_val[pin_n] = v;
      pin_n++;
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      while (!issue_valid && n < budget) begin
         tick();
         n++;
      end
      if (!issue_valid) pin(15, 32'd0);
   endtask

   logic [31:0] dec_word [5] = '{32'hFFF10113, 32'h40315193, 32'h02311093, 32'h00000033, 32'h7FF00193};
   logic [31:0] dec_imm  [5] = '{32'hFFFFFFFF, 32'h00000003, 32'h00000003, 32'h00000000, 32'h000007FF};
   logic [31:0] dec_rd   [5] = '{32'd2, 32'd3, 32'd1, 32'd0, 32'd3};
   logic [31:0] dec_rs1  [5] = '{32'd2, 32'd2, 32'd2, 32'd0, 32'd0};
   logic [31:0] dec_ill  [5] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd0};

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      issue_ready = 1'b1;
      mem_word    = 32'h00500093;
      mem_wait    = 0;
      pin_n       = 0;
      preset_seq  = 0;
      repeat (3) tick();
      rst = 1'b0;

      // sequential fetch with zero-wait memory
      pin(9, 32'd0);                         // req still low right after reset
      tick();
      pin(9, 32'd1); pin(0, 32'h100);
      tick();
      pin(8, 32'h100); pin(1, 32'd5); pin(2, 32'd1); pin(3, 32'd0); pin(4, 32'd0); pin(6, 32'd1);
      tick();
      pin(0, 32'h104); pin(6, 32'd0);
      tick();
      pin(8, 32'h104);
      tick();
      pin(0, 32'h108);
      tick();
      pin(8, 32'h108);
      tick();
      pin(5, 32'd3);
      issue_ready = 1'b0;
      tick();                                // 0x10C now held

      // decode table
      for (int i = 0; i < 5; i++) begin
         mem_word    = dec_word[i];
         issue_ready = 1'b1;
         tick();                             // fetch cycle, word acked
         issue_ready = 1'b0;
         tick();
         pin(7, dec_word[i]); pin(1, dec_imm[i]); pin(2, dec_rd[i]);
         pin(3, dec_rs1[i]); pin(4, dec_ill[i]);
      end

      // backpressure: hold for 5 cycles
      repeat (5) tick();
      pin(9, 32'd0); pin(6, 32'd1); pin(7, 32'h7FF00193);
      mem_wait    = 3;
      mem_word    = 32'h00500093;
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;

      // redirect in the 2nd wait cycle of a slow fetch
      pin(9, 32'd1);
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      tick();
      tick();                                // stale ack cycle
      pin(0, 32'h200); pin(9, 32'd1); pin(6, 32'd0);
      tick();
      wait_valid(20);
      pin(8, 32'h200);

      // redirect coincident with ack
      mem_wait    = 0;
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      tick();
      redirect = 1'b0;
      pin(0, 32'h300); pin(6, 32'd0);
      tick();
      pin(8, 32'h300);

      // redirect coincident with transfer
      issue_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h400;
      tick();
      issue_ready = 1'b0;
      redirect    = 1'b0;
      pin(0, 32'h400); pin(6, 32'd0);
      tick();
      pin(8, 32'h400);

      // redirect while holding, no transfer; low PC bits ignored
      redirect    = 1'b1;
      redirect_pc = 32'h503;
      tick();
      redirect = 1'b0;
      pin(6, 32'd0); pin(0, 32'h500);
      tick();
      pin(8, 32'h500);

      // PC wrap-around
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      tick();
      pin(8, 32'hFFFF_FFFC);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      pin(0, 32'h0000_0000);
      tick();
      pin(8, 32'h0000_0000);

      // issue_count wrap via a preset value
      force dut.count_q = 32'hFFFF_FFFF;
      preset_seq++;
      tick();
      release dut.count_q;
      pin(5, 32'hFFFF_FFFF);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      pin(5, 32'h0000_0000);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/i_fetch_decode.md
# i_fetch_decode

Front-end feeder for the I-type execution unit of the single-cycle RISC-V core. It fetches 32-bit instruction words from instruction memory with a request/acknowledge handshake and tracks the PC. It decodes each word into the operand fields the I-type unit consumes: raw instruction, sign-extended or shift-amount immediate, rs1 and rd indices, and an illegal flag. It then presents the decoded word on a valid/ready issue interface. It is the producing end of the instruction/immediate bus that the I-type unit reads.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  fetch address (current PC); stable while imem_req=1.
- imem_ack  in  1  memory accepted request; imem_rdata valid same cycle.
- imem_rdata  in  32  fetched instruction word.
- redirect  in  1  one-cycle pulse: discard current work, resume at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0).
- issue_valid  out  1  decoded instruction held on outputs.
- issue_ready  in  1  consumer accepts; transfer when issue_valid & issue_ready.
- idata  out  32  raw instruction word.
- imm  out  32  decoded immediate.
- rs1  out  5  instr[19:15].
- rd  out  5  instr[11:7].
- pc  out  32  address of the issued instruction.
- illegal  out  1  word is not a legal OP-IMM instruction.
- issue_count  out  32  number of completed issue transfers; wraps mod 2^32.

## Operation
- FSM states: FETCH, DRAIN, ISSUE.
- FETCH: imem_req=1, imem_addr=PC.
  - imem_ack without redirect: latch and decode imem_rdata, go to ISSUE.
  - redirect with no ack: PC←redirect_pc, go to DRAIN.
  - redirect with ack in the same cycle: discard the word, PC←redirect_pc, stay in FETCH.
- DRAIN: imem_req stays 1 with the old address until imem_ack. That response is discarded. Next state is FETCH using the new PC. A further redirect in DRAIN only updates the target PC.
- ISSUE: issue_valid=1; all decoded outputs are held stable.
  - Transfer without redirect: PC←PC+4 (wraps mod 2^32), issue_count+1, go to FETCH.
  - Redirect without transfer: the held word is dropped, PC←redirect_pc, go to FETCH.
  - Redirect and transfer in the same cycle: the transfer counts (issue_count+1), PC←redirect_pc, go to FETCH.
- Decode, latched at capture:
  - opcode=instr[6:0], funct3=instr[14:12].
  - funct3 001 (SLLI) or 101 (SRLI/SRAI): imm={27'b0, instr[24:20]}.
  - All other funct3: imm={{20{instr[31]}}, instr[31:20]}.
- illegal=1 in any of these cases:
  - opcode≠7'b0010011.
  - funct3=001 and instr[31:25]≠7'b0000000.
  - funct3=101 and instr[31:25] is neither 7'b0000000 nor 7'b0100000.
- Illegal words still issue normally, with illegal=1.

## Timing
- Reset (asynchronous, immediate):
  - FSM=FETCH, PC=RESET_PC.
  - imem_req=0 while rst=1. It rises in the first cycle after rst falls.
  - imem_addr=RESET_PC.
  - issue_valid=0, idata=0, imm=0, rs1=0, rd=0, pc=0, illegal=0, issue_count=0.
- Reset mid-operation: all state is abandoned. Any outstanding memory response after reset is not tracked; memory must be reset together with this block.
- Latency: imem_ack in cycle N → issue_valid=1 in cycle N+1.
- Throughput with zero-wait memory: one instruction per 2 cycles.
- issue_valid deasserts in the cycle after a transfer or redirect. It never drops without one of these.
- Outputs are registered. issue_ready and imem_ack have no combinational path to any output except through the FSM register.

## Test plan
- Reset and sequential fetch:
  - Stimulus: rst pulse, RESET_PC=0x100, zero-wait memory returning 0x00500093 (addi x1,x0,5), issue_ready=1.
  - Required: imem_addr sequence 0x100, 0x104, 0x108; imm=5, rs1=0, rd=1, illegal=0; issue_valid every 2nd cycle; issue_count=3 after 3 transfers.
- Negative immediate and shifts:
  - 0xFFF10113 → imm=0xFFFFFFFF, rd=2.
  - 0x40315193 (srai x3,x2,3) → imm=3, illegal=0.
  - 0x02311093 → illegal=1.
  - 0x00000033 (R-type) → illegal=1.
- Backpressure:
  - Stimulus: issue_ready=0 for 5 cycles after issue_valid rises.
  - Required: idata, imm and pc stable; no new imem_req; one transfer when ready rises.
- Redirect during wait-state fetch:
  - Stimulus: memory acks after 3 cycles; redirect to 0x200 in the 2nd wait cycle.
  - Required: the acked word is not issued; next imem_addr=0x200.
  - Also check redirect coincident with ack: word discarded, next fetch is 0x200.
- Redirect coincident with issue transfer:
  - Required: issue_count increments by 1; next imem_addr=redirect_pc.
  - Also check redirect during ISSUE without ready: no increment, issue_valid=0 next cycle.
- Wrap-around:
  - PC=0xFFFFFFFC with transfer → next imem_addr=0x00000000.
  - issue_count preset near 0xFFFFFFFF via 2^32−1 transfers is impractical; run a forced-value check instead: 0xFFFFFFFF + 1 transfer → 0.
